// File: rtl/monkey_sprite_blitter.sv
// monkey_sprite_blitter: walks a SPRITE_DIM x SPRITE_DIM 1-bit sprite ROM and writes its set pixels into the frame buffer.
// Ports: Clk/Reset (sync, active-high); start/pos_x/pos_y/sprite_color request a blit at a screen position;
// rom_addr_x/rom_addr_y/rom_data read the sprite ROM; fb_we/fb_addr/fb_data/fb_ready form the frame-buffer write port;
// busy is high while scanning, done pulses for one cycle when the blit completes.
module monkey_sprite_blitter #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int SPRITE_DIM = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [7:0]  sprite_color,
    output logic [9:0]  rom_addr_x,
    output logic [9:0]  rom_addr_y,
    input  logic        rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [7:0]  fb_data,
    input  logic        fb_ready,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(SPRITE_DIM);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
    localparam logic [2*AW-1:0] ONE = 1;

    logic [1:0]      state;
    logic [2*AW-1:0] idx;
    logic [AW-1:0]   row, col;
    logic [9:0]      lx, ly;
    logic [7:0]      color;
    logic [10:0]     px, py;
    logic            adv;

    // row-major pixel index: {row, col}, so a plain increment walks the sprite in scan order
    assign row = idx[2*AW-1:AW];
    assign col = idx[AW-1:0];
    assign rom_addr_x = 10'(col);
    assign rom_addr_y = 10'(row);

    // 11-bit sums so positions past the screen edge never wrap back into view
    assign px = {1'b0, lx} + 11'(col);
    assign py = {1'b0, ly} + 11'(row);

    assign fb_we   = (state == SCAN) && rom_data && (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
    assign fb_addr = 19'(py) * 19'(SCREEN_W) + 19'(px);
    assign fb_data = color;
    assign busy    = state == SCAN;
    assign done    = state == DONE;

    // a pending write holds the pixel until the frame buffer accepts it
    assign adv = (state == SCAN) && (!fb_we || fb_ready);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
            lx    <= '0;
            ly    <= '0;
            color <= '0;
        end else if (state == IDLE && start) begin
            lx    <= pos_x;
            ly    <= pos_y;
            color <= sprite_color;
            idx   <= '0;
            state <= SCAN;
        end else if (adv) begin
            idx   <= idx + ONE;
            state <= (&idx) ? DONE : SCAN;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_monkey_sprite_blitter.sv
// tb_monkey_sprite_blitter: scoreboard bench for monkey_sprite_blitter with a modelled sprite ROM.
module tb_monkey_sprite_blitter;
    logic        Clk = 0, Reset = 1, start = 0;
    logic [9:0]  pos_x = 0, pos_y = 0;
    logic [7:0]  sprite_color = 0;
    logic [9:0]  rom_addr_x, rom_addr_y;
    logic        rom_data, fb_we, fb_ready, busy, done;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;

    int errs = 0, checks = 0, cyc = 0;
    int done_cnt = 0, nwr = 0, busy_cnt = 0, done_cyc = 0, first_addr = -1;
    int stall_cnt = 0;
    bit bp = 0;
    logic [26:0] q[$];
    logic [26:0] e;
    logic        prev_stall = 0;
    logic [18:0] p_addr;
    logic [7:0]  p_data;
    logic [9:0]  p_rx, p_ry;

    monkey_sprite_blitter dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .sprite_color(sprite_color), .rom_addr_x(rom_addr_x), .rom_addr_y(rom_addr_y),
        .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // sprite: row 0 cols 15-16, rows 1-30 cols 4-15, row 31 cols 15-26 -> 374 set pixels
    function automatic logic rom_px(input int r, input int c);
        if (r == 0) return c == 15 || c == 16;
        if (r == 31) return c >= 15 && c <= 26;
        return c >= 4 && c <= 15;
    endfunction
    assign rom_data = rom_px(int'(rom_addr_y), int'(rom_addr_x));

    // backpressure: each write sees ready 0,0,1
    assign fb_ready = bp ? (stall_cnt == 2) : 1'b1;
    always @(posedge Clk) stall_cnt <= start ? 0 : fb_we ? (stall_cnt == 2 ? 0 : stall_cnt + 1) : stall_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_model(input int x, input int y, input int c);
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++)
                if (rom_px(r, k) && x + k < 640 && y + r < 480)
                    q.push_back({19'((y + r) * 640 + x + k), 8'(c)});
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge Clk);
        if (done_cnt == d0) chk("done_timeout", 1, 0);
    endtask

    task automatic blit(input int x, input int y, input int c, input bit b,
                        input int n_exp, input int first_exp, input bit restart);
        int s, d0, w0, b0, st;
        push_model(x, y, c);
        st = b ? 2 * n_exp : 0;
        d0 = done_cnt; w0 = nwr; b0 = busy_cnt; first_addr = -1;
        @(negedge Clk);
        bp = b; pos_x = 10'(x); pos_y = 10'(y); sprite_color = 8'(c); start = 1; s = cyc;
        @(negedge Clk);
        start = 0;
        if (restart) begin
            repeat (4) @(negedge Clk);
            pos_x = 0; pos_y = 0; sprite_color = 8'h55; start = 1;
            @(negedge Clk);
            start = 0;
            repeat (494) @(negedge Clk);
            start = 1;
            @(negedge Clk);
            start = 0;
        end
        wait_done(d0);
        chk("done_cycle", 64'(done_cyc), 64'(s + 1025 + st));
        repeat (3) @(negedge Clk);
        chk("done_pulses", 64'(done_cnt - d0), 1);
        chk("write_count", 64'(nwr - w0), 64'(n_exp));
        chk("queue_empty", 64'(q.size()), 0);
        chk("busy_cycles", 64'(busy_cnt - b0), 64'(1024 + st));
        if (first_exp >= 0) chk("first_addr", 64'(first_addr), 64'(first_exp));
        bp = 0;
    endtask

    initial begin
        int s, d0;
        fork
            forever begin
                @(negedge Clk);
                if (fb_we && fb_ready) begin
                    if (q.size() == 0) chk("unexpected_write", {45'd0, fb_addr}, 64'h7ffff);
                    else begin
                        e = q.pop_front();
                        chk("write", {fb_addr, fb_data}, e);
                    end
                    if (first_addr < 0) first_addr = int'(fb_addr);
                    nwr++;
                end
                if (prev_stall && !Reset) begin
                    chk("stall_addr", fb_addr, p_addr);
                    chk("stall_data", fb_data, p_data);
                    chk("stall_rom", {p_rx, p_ry}, {rom_addr_x, rom_addr_y});
                end
                prev_stall = fb_we && !fb_ready;
                p_addr = fb_addr; p_data = fb_data; p_rx = rom_addr_x; p_ry = rom_addr_y;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_quiet", {busy, fb_we}, 0);
                end
                if (busy) busy_cnt++;
            end
        join_none

        repeat (3) @(negedge Clk);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_rom_addr", {rom_addr_x, rom_addr_y}, 0);
        Reset = 0;

        blit(100, 50, 8'h2A, 0, 374, 32115, 0);
        blit(620, 0, 8'h11, 0, 367, 635, 0);
        blit(700, 10, 8'h77, 0, 0, -1, 0);
        blit(100, 50, 8'h2A, 1, 374, 32115, 0);
        blit(100, 50, 8'h2A, 0, 374, 32115, 1);

        push_model(100, 50, 8'h2A);
        d0 = done_cnt;
        @(negedge Clk);
        pos_x = 100; pos_y = 50; sprite_color = 8'h2A; start = 1; s = cyc;
        @(negedge Clk);
        start = 0;
        repeat (299) @(negedge Clk);
        chk("pre_reset_busy", busy, 1);
        Reset = 1;
        @(negedge Clk);
        chk("mid_rst_fb_we", fb_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fb_addr", fb_addr, 0);
        Reset = 0;
        q.delete();
        repeat (5) @(negedge Clk);
        chk("no_done_after_rst", 64'(done_cnt - d0), 0);
        blit(100, 50, 8'h2A, 0, 374, 32115, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/monkey_sprite_blitter.md
Name: monkey_sprite_blitter

Overview:
Reader-side consumer of the 32x32 1-bit monkey sprite ROM. On a start request it walks every sprite pixel: it drives the ROM X/Y address and samples the ROM data bit. Each set pixel becomes one write into the 640x480 frame buffer at the requested screen position. Clear pixels are transparent, and off-screen pixels are clipped. It sits between the game-logic tower placement and the frame-buffer write port.

Parameters:
SCREEN_W, 640, frame-buffer width in pixels; also the row stride for address generation
SCREEN_H, 480, frame-buffer height in pixels
SPRITE_DIM, 32, sprite edge length (power of two; row/column counters are log2(SPRITE_DIM) bits)

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to blit; sampled only in IDLE
pos_x  input  10  screen X of sprite top-left; latched on accepted start
pos_y  input  10  screen Y of sprite top-left; latched on accepted start
sprite_color  input  8  palette index written for set pixels; latched on accepted start
rom_addr_x  output  10  sprite ROM X address, {5'b0, col}
rom_addr_y  output  10  sprite ROM Y address, {5'b0, row}
rom_data  input  1  sprite ROM pixel bit; combinational, valid in the same cycle as the address
fb_we  output  1  frame-buffer write request
fb_addr  output  19  frame-buffer word address, y*SCREEN_W + x
fb_data  output  8  pixel value, the latched sprite_color
fb_ready  input  1  frame buffer accepts the write this cycle when fb_we && fb_ready
busy  output  1  high in SCAN
done  output  1  one-cycle pulse when the blit completes

Behaviour:
- Reset values:
  - state = IDLE; row, col = 0.
  - fb_we, busy, done = 0; fb_addr, fb_data = 0.
  - rom_addr_x, rom_addr_y = 0.
  - Latched pos and color = 0.
- Reset mid-blit: the next cycle is IDLE with all outputs at reset values. The partial blit is abandoned and no done pulse is issued.
- IDLE:
  - start=1 latches pos_x, pos_y and sprite_color, clears row/col and moves to SCAN.
  - start=0 stays in IDLE.
- SCAN evaluates the current pixel (row, col) each cycle:
  - rom_addr_x/rom_addr_y reflect row/col.
  - px = pos_x + col and py = pos_y + row, computed at 11 bits with no wrap.
  - visible = (px < SCREEN_W) && (py < SCREEN_H).
  - fb_we = rom_data && visible, combinational from the current state.
  - fb_addr = py*SCREEN_W + px, truncated to 19 bits; fb_data = latched color.
- Advancing to the next pixel:
  - If fb_we=0 (transparent or clipped), advance this cycle.
  - If fb_we=1, advance only in a cycle where fb_ready=1.
  - While fb_we=1 and fb_ready=0, hold: row, col, rom address, fb_addr and fb_data are stable.
- Pixel order is row-major: col increments 0..31, then col wraps to 0 and row increments.
- Completion:
  - The pixel at row=31, col=31 advances -> DONE.
  - DONE lasts one cycle: done=1, busy=0, fb_we=0, then return to IDLE.
  - start is accepted again in the cycle after DONE.
- start while in SCAN or DONE is ignored; the latched values are unchanged.
- Latency with fb_ready tied high:
  - start sampled at edge 0; pixels are evaluated in cycles 1..1024; done is high in cycle 1025.
  - Total is always exactly 1024 SCAN cycles plus the stall cycles.
- A fully off-screen sprite (pos_x >= 640 or pos_y >= 480) still scans all 1024 pixels with zero writes, then pulses done.
- Each fb_we=1 cycle with fb_ready=1 is exactly one accepted write. No write is duplicated or dropped.

Test Plan:
- Reset, then start with pos=(100,50), color=8'h2A, fb_ready=1:
  - first write is fb_addr=32115 (row 0, col 15), then 32116;
  - 374 writes total, all with fb_data=8'h2A;
  - done is high in cycle 1025 only.
- pos=(620,0): only cols 0..19 are written. Row 0 writes addr 635 and 636. No px >= 640 ever appears; done is still at cycle 1025.
- pos=(700,10): zero fb_we cycles, busy for 1024 cycles, then a single done pulse.
- Backpressure: fb_ready toggles 0,0,1 repeatedly:
  - fb_addr/fb_data/rom address stay stable while stalled;
  - 374 accepted writes, in the same order as the unstalled run;
  - done arrives 2*374 cycles later than the unstalled run.
- start asserted again at cycles 5 and 500 of a blit: ignored; latched pos unchanged; exactly one done pulse.
- Reset asserted in cycle 300 of a blit:
  - next cycle fb_we=0, busy=0, and done does not pulse;
  - a subsequent start runs a full, correct blit.
